// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared encodings for the CPU run/halt/step sequencer:
//   - host command opcodes (cmd_op)
//   - halt cause codes reported on halt_cause
//   - run_control state encoding
package cpu_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_HALT = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'b00,
    CAUSE_HOST  = 2'b01,
    CAUSE_STEP  = 2'b10,
    CAUSE_BP    = 2'b11
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_DRAIN  = 2'b11
  } rc_state_e;

endpackage

// File: rtl/retire_counter.sv
// retire_counter
// Free-running CNT_W-bit counter of retired instructions. Wraps modulo
// 2^CNT_W and is never stalled.
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-high (clears the count)
//   i_en    increment enable (one retire pulse)
//   o_count current count (registered)
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_control.sv
// run_control
// Run/halt/single-step sequencer between a host command port and the
// control FSM of the multi-cycle core. The core is gated through core_en
// and only ever stops at an instruction boundary (the retire pulse).
// Optional breakpoint support is compiled in with macro RUN_CTRL_BP_EN.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_op/cmd_count     host command (NOP/RUN/STEP/HALT)
//   cmd_ready                      decoded from state (HALTED or RUN)
//   cmd_err                        one-cycle pulse for an illegal command
//   retire, pc                     instruction-complete pulse and its PC
//   core_en, halted, halt_cause    core gating and stop status
//   instr_count                    retired-instruction counter
//   bp_addr, bp_valid              breakpoint (RUN_CTRL_BP_EN only)
module run_control
  import cpu_pkg::*;
#(
  parameter int PC_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             cmd_err,
  input  logic             retire,
  input  logic [PC_W-1:0]  pc,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count
`ifdef RUN_CTRL_BP_EN
  ,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid
`endif
);

  rc_state_e        r_state;
  logic [CNT_W-1:0] r_step_cnt;
  logic             w_accept;
  logic             w_bp_hit;
  cmd_op_e          w_op;

  assign w_op      = cmd_op_e'(cmd_op);
  assign cmd_ready = (r_state == ST_HALTED) || (r_state == ST_RUN);
  assign w_accept  = cmd_valid && cmd_ready;

`ifdef RUN_CTRL_BP_EN
  // Matching on pc+1 stops the core before the instruction at bp_addr runs;
  // resuming from bp_addr retires it first, so it never re-triggers there.
  assign w_bp_hit = bp_valid && ((pc + PC_W'(1)) == bp_addr);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign w_bp_hit    = 1'b0;
`endif

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (retire),
    .o_count (instr_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HALTED;
      r_step_cnt <= '0;
      core_en    <= 1'b0;
      halted     <= 1'b1;
      halt_cause <= CAUSE_RESET;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (r_state)
        ST_HALTED: begin
          // A retire here means the core was not parked; flag it.
          if (retire) cmd_err <= 1'b1;
          if (w_accept) begin
            case (w_op)
              CMD_RUN: begin
                r_state <= ST_RUN;
                core_en <= 1'b1;
                halted  <= 1'b0;
              end
              CMD_STEP: begin
                r_state    <= ST_STEP;
                r_step_cnt <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                core_en    <= 1'b1;
                halted     <= 1'b0;
              end
              CMD_HALT: cmd_err <= 1'b1;
              default: ;
            endcase
          end
        end

        ST_RUN: begin
          if (w_accept && (w_op == CMD_HALT)) begin
            // Host HALT outranks a breakpoint on the same retire.
            if (retire) begin
              r_state    <= ST_HALTED;
              core_en    <= 1'b0;
              halted     <= 1'b1;
              halt_cause <= CAUSE_HOST;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            if (w_accept && ((w_op == CMD_RUN) || (w_op == CMD_STEP))) begin
              cmd_err <= 1'b1;
            end
            if (retire && w_bp_hit) begin
              r_state    <= ST_HALTED;
              core_en    <= 1'b0;
              halted     <= 1'b1;
              halt_cause <= CAUSE_BP;
            end
          end
        end

        ST_STEP: begin
          if (retire) begin
            r_step_cnt <= r_step_cnt - CNT_W'(1);
            if (w_bp_hit) begin
              r_state    <= ST_HALTED;
              core_en    <= 1'b0;
              halted     <= 1'b1;
              halt_cause <= CAUSE_BP;
            end else if (r_step_cnt == CNT_W'(1)) begin
              r_state    <= ST_HALTED;
              core_en    <= 1'b0;
              halted     <= 1'b1;
              halt_cause <= CAUSE_STEP;
            end
          end
        end

        ST_DRAIN: begin
          if (retire) begin
            r_state    <= ST_HALTED;
            core_en    <= 1'b0;
            halted     <= 1'b1;
            halt_cause <= CAUSE_HOST;
          end
        end

        default: begin
          r_state <= ST_HALTED;
          core_en <= 1'b0;
          halted  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_control.sv
// Testbench for run_control: table of per-cycle vectors followed by
// hand-written sequences (counter wrap, asynchronous reset, breakpoint).
module tb_run_control;

  localparam int PC_W  = 5;
  localparam int CNT_W = 16;
  localparam int NV    = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_ready;
  logic             cmd_err;
  logic             retire = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             core_en;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] instr_count;
`ifdef RUN_CTRL_BP_EN
  logic [PC_W-1:0]  bp_addr = '0;
  logic             bp_valid = 1'b0;
`endif

  run_control #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .cmd_ready   (cmd_ready),
    .cmd_err     (cmd_err),
    .retire      (retire),
    .pc          (pc),
    .core_en     (core_en),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .instr_count (instr_count)
`ifdef RUN_CTRL_BP_EN
    ,
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;     // cmd_valid
    int op;    // cmd_op
    int cnt;   // cmd_count
    int ret;   // retire
    int en;    // expected core_en
    int h;     // expected halted
    int c;     // expected halt_cause
    int e;     // expected cmd_err
    int rdy;   // expected cmd_ready
    int icnt;  // expected instr_count
  } vec_t;

  vec_t vecs[NV];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input int v, input int op, input int cnt, input int ret);
    @(negedge clk);
    cmd_valid = v[0];
    cmd_op    = 2'(op);
    cmd_count = CNT_W'(cnt);
    retire    = ret[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Inputs applied in one cycle -> outputs seen after that cycle's edge.
    //            v op cnt ret  en h  c  e  rdy icnt
    vecs[0]  = '{0, 0, 0, 0,   0, 1, 0, 0, 1, 0};   // idle after reset
    vecs[1]  = '{1, 2, 3, 0,   1, 0, 0, 0, 0, 0};   // STEP 3
    vecs[2]  = '{0, 0, 0, 1,   1, 0, 0, 0, 0, 1};
    vecs[3]  = '{0, 0, 0, 0,   1, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, 1,   1, 0, 0, 0, 0, 2};
    vecs[5]  = '{0, 0, 0, 1,   0, 1, 2, 0, 1, 3};   // 3rd retire halts
    vecs[6]  = '{1, 2, 0, 0,   1, 0, 2, 0, 0, 3};   // STEP 0 -> 1
    vecs[7]  = '{0, 0, 0, 1,   0, 1, 2, 0, 1, 4};
    vecs[8]  = '{1, 3, 0, 0,   0, 1, 2, 1, 1, 4};   // HALT while HALTED
    vecs[9]  = '{0, 0, 0, 0,   0, 1, 2, 0, 1, 4};
    vecs[10] = '{1, 1, 0, 0,   1, 0, 2, 0, 1, 4};   // RUN
    vecs[11] = '{1, 1, 0, 0,   1, 0, 2, 1, 1, 4};   // RUN again -> err
    vecs[12] = '{0, 0, 0, 0,   1, 0, 2, 0, 1, 4};
    vecs[13] = '{0, 0, 0, 1,   1, 0, 2, 0, 1, 5};
    vecs[14] = '{1, 3, 0, 0,   1, 0, 2, 0, 0, 5};   // HALT mid-instr -> DRAIN
    vecs[15] = '{1, 3, 0, 0,   1, 0, 2, 0, 0, 5};   // not accepted in DRAIN
    vecs[16] = '{0, 0, 0, 1,   0, 1, 1, 0, 1, 6};
    vecs[17] = '{1, 1, 0, 0,   1, 0, 1, 0, 1, 6};   // RUN
    vecs[18] = '{1, 3, 0, 1,   0, 1, 1, 0, 1, 7};   // HALT with retire
    vecs[19] = '{1, 2, 2, 0,   1, 0, 1, 0, 0, 7};   // STEP 2
    vecs[20] = '{1, 2, 5, 1,   1, 0, 1, 0, 0, 8};   // STEP ignored in STEP
    vecs[21] = '{0, 0, 0, 1,   0, 1, 2, 0, 1, 9};
    vecs[22] = '{0, 0, 0, 1,   0, 1, 2, 1, 1, 10};  // retire while HALTED
    vecs[23] = '{0, 0, 0, 0,   0, 1, 2, 0, 1, 10};

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst.core_en", int'(core_en), 0);
    chk("rst.halted", int'(halted), 1);
    chk("rst.cause", int'(halt_cause), 0);
    chk("rst.ready", int'(cmd_ready), 1);
    chk("rst.count", int'(instr_count), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].v, vecs[i].op, vecs[i].cnt, vecs[i].ret);
      chk($sformatf("v%0d.core_en", i), int'(core_en), vecs[i].en);
      chk($sformatf("v%0d.halted", i), int'(halted), vecs[i].h);
      chk($sformatf("v%0d.cause", i), int'(halt_cause), vecs[i].c);
      chk($sformatf("v%0d.cmd_err", i), int'(cmd_err), vecs[i].e);
      chk($sformatf("v%0d.ready", i), int'(cmd_ready), vecs[i].rdy);
      chk($sformatf("v%0d.count", i), int'(instr_count), vecs[i].icnt);
      $display("vec %0d: v=%0d op=%0d cnt=%0d ret=%0d -> en=%0d h=%0d c=%0d e=%0d rdy=%0d icnt=%0d",
               i, vecs[i].v, vecs[i].op, vecs[i].cnt, vecs[i].ret,
               core_en, halted, halt_cause, cmd_err, cmd_ready, instr_count);
    end

    // Counter wrap: RUN, retire continuously up to 0xFFFF, then one more.
    cyc(1, 1, 0, 0);
    chk("wrap.run.core_en", int'(core_en), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    retire    = 1'b1;
    repeat (65535 - 10) @(posedge clk);
    @(negedge clk);
    retire = 1'b0;
    chk("wrap.preload", int'(instr_count), 65535);
    cyc(0, 0, 0, 1);
    chk("wrap.zero", int'(instr_count), 0);
    chk("wrap.still_run", int'(core_en), 1);
    $display("wrap: instr_count=%0h core_en=%0d", instr_count, core_en);

    // Asynchronous reset mid-instruction.
    cyc(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.core_en", int'(core_en), 0);
    chk("arst.halted", int'(halted), 1);
    chk("arst.cause", int'(halt_cause), 0);
    chk("arst.count", int'(instr_count), 0);
    chk("arst.ready", int'(cmd_ready), 1);
    $display("async reset: core_en=%0d halted=%0d cause=%0d", core_en, halted, halt_cause);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk("arst.after.core_en", int'(core_en), 0);

`ifdef RUN_CTRL_BP_EN
    begin
      int n_ret;
      int last_pc;
      n_ret   = 0;
      last_pc = -1;
      bp_addr  = 5'd5;
      bp_valid = 1'b1;
      cyc(1, 1, 0, 0);
      for (int k = 0; k < 20; k++) begin
        pc = PC_W'(k);
        cyc(0, 0, 0, 1);
        n_ret++;
        last_pc = k;
        if (halted) break;
      end
      retire = 1'b0;
      chk("bp.retires", n_ret, 5);
      chk("bp.last_pc", last_pc, 4);
      chk("bp.halted", int'(halted), 1);
      chk("bp.cause", int'(halt_cause), 3);
      chk("bp.count", int'(instr_count), 5);
      $display("bp: halted after %0d retires, cause=%0d", n_ret, halt_cause);
      // Resume from bp_addr: pc=5 retires without re-halting.
      cyc(1, 1, 0, 0);
      pc = 5'd5;
      cyc(0, 0, 0, 1);
      chk("bp.resume.halted", int'(halted), 0);
      chk("bp.resume.core_en", int'(core_en), 1);
      pc = 5'd6;
      cyc(0, 0, 0, 1);
      chk("bp.resume2.halted", int'(halted), 0);
      cyc(1, 3, 0, 1);
      chk("bp.stop.cause", int'(halt_cause), 1);
      $display("bp resume: halted=%0d cause=%0d count=%0d", halted, halt_cause, instr_count);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_control.md
Name: run_control

Overview:
- Run/halt/single-step sequencer for the multi-cycle CPU core.
- Sits between a host/debug command port and the control FSM.
- Gates the control FSM via core_en and stops only at instruction boundaries, marked by the retire pulse, which is the FSM's pc_enable.
- Counts retired instructions and reports why the core stopped.

Parameters:
- PC_W, 5, width of program counter / breakpoint address
- CNT_W, 16, width of step count and retire counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  host command valid
- cmd_op  in  2  command: 00 NOP, 01 RUN, 10 STEP, 11 HALT
- cmd_count  in  CNT_W  instructions to execute for STEP (0 treated as 1)
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_err  out  1  one-cycle pulse: accepted command illegal in current state
- retire  in  1  instruction-complete pulse from control FSM (INC_PC state)
- pc  in  PC_W  current PC; during retire, address of the retiring instruction
- core_en  out  1  control FSM may advance when 1
- halted  out  1  1 in HALTED state
- halt_cause  out  2  00 reset, 01 host HALT, 10 step done, 11 breakpoint
- instr_count  out  CNT_W  retired-instruction counter
- bp_addr  in  PC_W  breakpoint address (RUN_CTRL_BP_EN only)
- bp_valid  in  1  breakpoint armed (RUN_CTRL_BP_EN only)

Behaviour:
- Reset values:
  - state HALTED
  - core_en 0, halted 1, halt_cause 00
  - instr_count 0, step counter 0
  - cmd_err 0, cmd_ready 1
- Reset is asynchronous: asserting rst mid-instruction drops core_en immediately and clears all state.
- All outputs are registered except cmd_ready, which is decoded from state.
- States: HALTED, RUN, STEP, DRAIN. core_en is 1 in RUN, STEP and DRAIN.
- cmd_ready is 1 in HALTED and RUN, and 0 in STEP and DRAIN.
- HALTED:
  - RUN -> RUN.
  - STEP -> STEP; step counter loads max(cmd_count,1).
  - HALT or NOP -> stay; HALT also pulses cmd_err.
  - Accepted in cycle T -> core_en=1 from T+1.
- RUN:
  - HALT with retire in the same cycle -> HALTED at next edge, cause 01.
  - HALT without retire -> DRAIN.
  - RUN or STEP -> ignored, cmd_err pulse.
- DRAIN: wait for retire, then -> HALTED, cause 01.
- STEP:
  - On each retire, decrement the step counter.
  - On the retire where the counter is 1 -> HALTED, cause 10.
- Halt latency: retire in cycle R with a stop condition -> core_en=0 and halted=1 at R+1. The control FSM is then parked in FETCH.
- instr_count increments on every retire in any state. It wraps modulo 2^CNT_W and is never stalled.
- retire while HALTED must not occur; if it does, count it and pulse cmd_err.
- PC wrap (31->0) is not a stop condition.
- Priority on the same retire: host HALT > breakpoint > step done.

Optional Feature:
- Macro RUN_CTRL_BP_EN.
- Defined:
  - On retire in RUN or STEP with bp_valid=1 and (pc+1) mod 2^PC_W == bp_addr -> HALTED, cause 11.
  - The core therefore stops before executing the instruction at bp_addr.
  - Resuming from bp_addr executes that instruction first, because the check is done only on retire.
- Undefined: the bp_addr and bp_valid ports are absent and cause 11 never occurs.

Decomposition:
- Shared package cpu_pkg holds:
  - cmd_op codes (CMD_NOP/RUN/STEP/HALT)
  - halt_cause codes (CAUSE_RESET/HOST/STEP/BP)
  - run_control state encoding
- One sub-module, retire_counter (CNT_W-bit wrapping counter with increment enable), is natural. The step down-counter stays inline.

Test Plan:
- Reset, then STEP with cmd_count=3 -> exactly 3 retires, halted=1 one cycle after the 3rd, halt_cause=10, instr_count=3.
- STEP with cmd_count=0 -> exactly 1 retire, halt_cause=10.
- RUN, then HALT issued mid-instruction -> DRAIN, cmd_ready=0, halt after the next retire, halt_cause=01. HALT coincident with retire -> halt the next cycle with no extra instruction.
- RUN, then RUN again -> cmd_err pulses for one cycle and state stays RUN. HALT while HALTED -> cmd_err pulses.
- With RUN_CTRL_BP_EN, bp_addr=5, bp_valid=1, RUN from pc=0 -> halt after the pc=4 retire, cause 11. A second RUN executes pc=5 and does not re-halt there.
- Preload instr_count to 0xFFFF via retires, then one more retire -> instr_count=0x0000. Assert rst mid-instruction -> core_en=0 immediately, halt_cause=00.
